// File: rtl/data_ram_arbiter.sv
// Two-master round-robin arbiter in front of one multi-cycle data RAM, with an access watchdog.
module data_ram_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_din,
    output logic [31:0]   m0_dout,
    output logic          m0_ack,
    output logic          m0_err,
    output logic          m0_stall,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_din,
    output logic [31:0]   m1_dout,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          m1_stall,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout,
    input  logic          ram_ack,
    output logic          owner,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RECOVER} state_t;

    state_t             state, state_n;
    logic               owner_n;
    logic               rr_last, rr_last_n;
    logic [CNT_W-1:0]   wdog, wdog_n;
    logic               we_n;
    logic [AW-1:0]      addr_n;
    logic [31:0]        din_n;
    logic               grant;
    logic               grant_id;
    logic               done;
    logic               timeout;

    // Next-state, arbitration and request capture
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        rr_last_n = rr_last;
        wdog_n    = wdog;
        we_n      = ram_we;
        addr_n    = ram_addr;
        din_n     = ram_din;
        grant     = 1'b0;
        grant_id  = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;

        case (state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    grant    = 1'b1;
                    grant_id = (m0_req && m1_req) ? ~rr_last : m1_req;
                    state_n  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ram_ack) begin
                    done      = 1'b1;
                    rr_last_n = owner;
                    wdog_n    = '0;
                    // Only the other master may be granted back-to-back
                    if (owner ? m0_req : m1_req) begin
                        grant    = 1'b1;
                        grant_id = ~owner;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (wdog == CNT_W'(TIMEOUT)) begin
                    timeout   = 1'b1;
                    rr_last_n = owner;
                    wdog_n    = '0;
                    state_n   = S_RECOVER;
                end else begin
                    wdog_n = wdog + CNT_W'(1);
                end
            end
            S_RECOVER: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (grant) begin
            owner_n = grant_id;
            wdog_n  = '0;
            we_n    = grant_id ? m1_we   : m0_we;
            addr_n  = grant_id ? m1_addr : m0_addr;
            din_n   = grant_id ? m1_din  : m0_din;
        end
    end

    // State, capture and RAM-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= 1'b0;
            rr_last  <= 1'b1;
            wdog     <= '0;
            ram_cs   <= 1'b0;
            busy     <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_last  <= rr_last_n;
            wdog     <= wdog_n;
            ram_cs   <= (state_n == S_BUSY);
            busy     <= (state_n == S_BUSY);
            ram_we   <= we_n;
            ram_addr <= addr_n;
            ram_din  <= din_n;
        end
    end

    // Master-side strobes follow the RAM ack in the same cycle; silenced during reset
    always_comb begin
        m0_ack   = ~rst & done & ~owner;
        m1_ack   = ~rst & done &  owner;
        m0_err   = ~rst & timeout & ~owner;
        m1_err   = ~rst & timeout &  owner;
        m0_dout  = m0_ack ? ram_dout : 32'h0;
        m1_dout  = m1_ack ? ram_dout : 32'h0;
        m0_stall = m0_req & ~m0_ack & ~m0_err;
        m1_stall = m1_req & ~m1_ack & ~m1_err;
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter with a 4-cycle-ack RAM model.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_din = '0, m1_addr = '0, m1_din = '0;
    logic [31:0] m0_dout, m1_dout;
    logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
    logic        ram_cs, ram_we, ram_ack, owner, busy;
    logic [31:0] ram_addr, ram_din, ram_dout;

    data_ram_arbiter #(.AW(32), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_dout(m0_dout), .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_dout(m1_dout), .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_ack(ram_ack), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: acks in the 4th consecutive cs cycle, writes on ack
    logic [31:0] mem [256];
    int          ram_cnt = 0;
    bit          ram_silent = 1'b0;
    bit          mem_loaded = 1'b0;
    assign ram_ack  = ram_cs && !ram_silent && (ram_cnt == 3);
    assign ram_dout = mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (rst && !mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h04] <= 32'hCAFE0001;   // byte addr 0x10
            mem[8'h0C] <= 32'h55AA55AA;   // byte addr 0x30
            mem_loaded <= 1'b1;
        end else if (ram_ack && ram_we) begin
            mem[ram_addr[9:2]] <= ram_din;
        end
        if (rst || !ram_cs || ram_ack) ram_cnt <= 0;
        else                           ram_cnt <= ram_cnt + 1;
    end

    typedef struct {
        bit          m;
        bit          err;
        bit          chk;
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_rsp(input bit m, input bit err, input bit chk,
                                       input logic [31:0] d, input int c);
        exp_t e;
        e.m = m; e.err = err; e.chk = chk; e.dout = d; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    task automatic score(input bit m, input bit err, input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: master %0d err %0d at cycle %0d, none expected", m, err, cyc);
        end else begin
            e = exp_q.pop_front();
            check("rsp_master", 32'(m), 32'(e.m));
            check("rsp_kind", 32'(err), 32'(e.err));
            check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            if (e.chk) check("rsp_dout", d, e.dout);
        end
    endtask

    // Monitor: every strobe pops the scoreboard; idle read data must be zero
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_ack || m0_err) score(1'b0, m0_err, m0_dout);
            if (m1_ack || m1_err) score(1'b1, m1_err, m1_dout);
            if (!m0_ack) check("m0_dout_idle", m0_dout, 32'h0);
            if (!m1_ack) check("m1_dout_idle", m1_dout, 32'h0);
        end
    end

    // Raise a request and hold it until that master is strobed (bounded)
    task automatic do_req(input bit m, input bit we, input logic [31:0] addr, input logic [31:0] din);
        bit done = 1'b0;
        if (m) begin m1_we = we; m1_addr = addr; m1_din = din; m1_req = 1'b1; end
        else   begin m0_we = we; m0_addr = addr; m0_din = din; m0_req = 1'b1; end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m ? (m1_ack || m1_err) : (m0_ack || m0_err)) begin
                done = 1'b1;
                break;
            end
        end
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL req_timeout: master %0d got no response within 60 cycles", m);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int t;
    int acks;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ram_cs", 32'(ram_cs), 32'h0);
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_owner",  32'(owner),  32'h0);
        check("reset_acks",   32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Uncontended read, latency 4
        t = cyc; expect_rsp(1'b0, 1'b0, 1'b1, 32'hCAFE0001, t + 4);
        do_req(1'b0, 1'b0, 32'h10, 32'h0);
        next_cycle();

        // Write then read back
        t = cyc; expect_rsp(1'b1, 1'b0, 1'b0, 32'h0, t + 4);
        do_req(1'b1, 1'b1, 32'h20, 32'h12345678);
        next_cycle();
        t = cyc; expect_rsp(1'b1, 1'b0, 1'b1, 32'h12345678, t + 4);
        do_req(1'b1, 1'b0, 32'h20, 32'h0);
        next_cycle();

        // Simultaneous pair after m1 was last served: m0 first, m1 back-to-back
        t = cyc;
        expect_rsp(1'b0, 1'b0, 1'b1, 32'hCAFE0001, t + 4);
        expect_rsp(1'b1, 1'b0, 1'b1, 32'h12345678, t + 8);
        fork
            do_req(1'b0, 1'b0, 32'h10, 32'h0);
            do_req(1'b1, 1'b0, 32'h20, 32'h0);
        join
        next_cycle();

        // Single m0 access, so the following pair goes to m1 first
        t = cyc; expect_rsp(1'b0, 1'b0, 1'b1, 32'h12345678, t + 4);
        do_req(1'b0, 1'b0, 32'h20, 32'h0);
        next_cycle();
        t = cyc;
        expect_rsp(1'b1, 1'b0, 1'b0, 32'h0, t + 4);
        expect_rsp(1'b0, 1'b0, 1'b1, 32'hCAFE0001, t + 8);
        fork
            do_req(1'b0, 1'b0, 32'h10, 32'h0);
            do_req(1'b1, 1'b1, 32'h40, 32'hA5A5F00D);
        join
        next_cycle();

        // m0 holds req continuously: one idle cycle between accesses
        t = cyc;
        expect_rsp(1'b0, 1'b0, 1'b1, 32'hA5A5F00D, t + 4);
        expect_rsp(1'b0, 1'b0, 1'b1, 32'hA5A5F00D, t + 9);
        expect_rsp(1'b0, 1'b0, 1'b1, 32'hA5A5F00D, t + 14);
        m0_we = 1'b0; m0_addr = 32'h40; m0_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 60 && acks < 3; i++) begin
            @(negedge clk);
            if (m0_ack) acks++;
        end
        m0_req = 1'b0;
        check("hold_ack_count", 32'(acks), 32'd3);
        next_cycle();

        // Silent RAM: error after 16 busy cycles, then one recover cycle with cs low
        ram_silent = 1'b1;
        t = cyc; expect_rsp(1'b1, 1'b1, 1'b0, 32'h0, t + 16);
        do_req(1'b1, 1'b0, 32'h10, 32'h0);
        check("timeout_cs_in_err_cycle", 32'(ram_cs), 32'h1);
        @(negedge clk);
        check("recover_cs", 32'(ram_cs), 32'h0);
        check("recover_busy", 32'(busy), 32'h0);
        ram_silent = 1'b0;
        next_cycle();
        next_cycle();

        // Reset two cycles into a write: no strobe, RAM word untouched
        t = cyc;
        m0_we = 1'b1; m0_addr = 32'h30; m0_din = 32'hDEADBEEF; m0_req = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        m0_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cs", 32'(ram_cs), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        next_cycle();
        t = cyc; expect_rsp(1'b0, 1'b0, 1'b1, 32'h55AA55AA, t + 4);
        do_req(1'b0, 1'b0, 32'h30, 32'h0);
        next_cycle();

        // Address change after grant does not affect the access in flight
        t = cyc; expect_rsp(1'b1, 1'b0, 1'b1, 32'hCAFE0001, t + 4);
        fork
            do_req(1'b1, 1'b0, 32'h10, 32'h0);
            begin
                next_cycle();
                m1_addr = 32'h20;
            end
        join
        next_cycle();

        repeat (5) next_cycle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
